// File: rtl/udp_axis_serializer.sv
// Serialises one captured UDP packet bundle into a 32-bit AXI4-Stream:
// two header beats, then payload beats with tkeep/tlast on the final one.
module udp_axis_serializer #(
  parameter int DATA_BYTES = 64,
  parameter int AXIS_BYTES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*DATA_BYTES-1:0]   in_data,
  input  logic [15:0]               in_len,
  input  logic [15:0]               in_src_port,
  input  logic [15:0]               in_dst_port,
  input  logic [15:0]               in_length,
  input  logic [15:0]               in_checksum,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [8*AXIS_BYTES-1:0]   out_tdata,
  output logic [AXIS_BYTES-1:0]     out_tkeep,
  output logic                      out_tlast,
  output logic                      len_clamped,
  output logic [15:0]               pkt_count
);

  localparam int LEN_W      = $clog2(DATA_BYTES + 1);
  localparam int NWORDS_MAX = DATA_BYTES / AXIS_BYTES;
  localparam int WORD_W     = (NWORDS_MAX > 1) ? $clog2(NWORDS_MAX) : 1;
  localparam int REM_W      = $clog2(AXIS_BYTES);
  localparam int BEAT_W     = 8 * AXIS_BYTES;
  localparam int SHIFT_W    = $clog2(BEAT_W);
  localparam logic [15:0] MAX_LEN = 16'(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;

  state_t                    r_state, w_next;
  logic [8*DATA_BYTES-1:0]   r_data;
  logic [15:0]               r_src, r_dst, r_length, r_cksum;
  logic [LEN_W-1:0]          r_eff_len;
  logic [WORD_W-1:0]         r_last_word, r_word;
  logic                      r_clamped;
  logic [15:0]               r_pkt_count;

  logic                      w_capture;
  logic [LEN_W-1:0]          w_eff_len;
  logic [LEN_W:0]            w_nwords;
  logic                      w_pay_last;
  logic [WORD_W+SHIFT_W-1:0] w_bit_idx;
  logic [BEAT_W-1:0]         w_pay_word;
  logic [REM_W-1:0]          w_rem;
  logic [AXIS_BYTES-1:0]     w_last_keep;

  assign w_capture  = in_valid && in_ready;
  assign w_eff_len  = (in_len > MAX_LEN) ? LEN_W'(DATA_BYTES) : in_len[LEN_W-1:0];
  assign w_nwords   = ({1'b0, w_eff_len} + (LEN_W+1)'(AXIS_BYTES - 1)) >> REM_W;
  assign w_pay_last = (r_word == r_last_word);
  assign w_bit_idx  = {r_word, SHIFT_W'(0)};
  assign w_pay_word = r_data[w_bit_idx +: BEAT_W];
  assign w_rem      = r_eff_len[REM_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: the bundle registers carry no reset; they are only read after a
  // capture, and reset alone returns the FSM to IDLE, discarding them.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_data      <= in_data;
      r_src       <= in_src_port;
      r_dst       <= in_dst_port;
      r_length    <= in_length;
      r_cksum     <= in_checksum;
      r_eff_len   <= w_eff_len;
      r_last_word <= WORD_W'(w_nwords - (LEN_W+1)'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_word      <= '0;
      r_clamped   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_clamped <= w_capture && (in_len > MAX_LEN);
      if (w_capture)
        r_word <= '0;
      else if (r_state == PAY && out_tready)
        r_word <= w_pay_last ? '0 : r_word + WORD_W'(1);
      if (out_tvalid && out_tready && out_tlast)
        r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  always_comb begin
    for (int j = 0; j < AXIS_BYTES; j++)
      w_last_keep[j] = (w_rem == '0) || (32'(w_rem) > j);
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = reset;
        if (in_valid && reset) w_next = HDR0;
      end
      HDR0: begin
        out_tvalid = 1'b1;
        out_tdata  = BEAT_W'({r_dst, r_src});
        out_tkeep  = '1;
        if (out_tready) w_next = HDR1;
      end
      HDR1: begin
        out_tvalid = 1'b1;
        out_tdata  = BEAT_W'({r_cksum, r_length});
        out_tkeep  = '1;
        out_tlast  = (r_eff_len == '0);
        if (out_tready) w_next = (r_eff_len == '0) ? IDLE : PAY;
      end
      PAY: begin
        out_tvalid = 1'b1;
        out_tkeep  = w_pay_last ? w_last_keep : '1;
        out_tlast  = w_pay_last;
        // Bytes beyond the packet end are forced to zero, not left as stale payload.
        for (int j = 0; j < AXIS_BYTES; j++)
          out_tdata[8*j +: 8] = out_tkeep[j] ? w_pay_word[8*j +: 8] : 8'h00;
        if (out_tready && w_pay_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign len_clamped = r_clamped;
  assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_udp_axis_serializer.sv
// Directed bench for udp_axis_serializer: header/payload beats, zero-length,
// full and clamped lengths, back-pressure and mid-packet reset.
module tb_udp_axis_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic [15:0]  in_len, in_src_port, in_dst_port, in_length, in_checksum;
  logic         out_tvalid, out_tready;
  logic [31:0]  out_tdata;
  logic [3:0]   out_tkeep;
  logic         out_tlast;
  logic         len_clamped;
  logic [15:0]  pkt_count;

  int n_cmp = 0;
  int n_mis = 0;

  udp_axis_serializer #(.DATA_BYTES(64), .AXIS_BYTES(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .in_src_port(in_src_port), .in_dst_port(in_dst_port),
    .in_length(in_length), .in_checksum(in_checksum),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .len_clamped(len_clamped), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a bundle for one capture edge, then scrambles the inputs.
  task automatic send(input logic [15:0] len, input logic [15:0] src, input logic [15:0] dst,
                      input logic [15:0] lenf, input logic [15:0] ck, input logic [511:0] pl);
    in_valid = 1'b1; in_len = len; in_src_port = src; in_dst_port = dst;
    in_length = lenf; in_checksum = ck; in_data = pl;
    @(negedge clock);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = ~pl; in_len = 16'h0003; in_src_port = 16'hDEAD;
    in_dst_port = 16'hBEEF; in_length = 16'hFFFF; in_checksum = 16'h5A5A;
  endtask

  task automatic recv_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic l, input int stall, input logic clamp);
    for (int i = 0; i < stall; i++) begin
      out_tready = 1'b0;
      @(negedge clock);
      check({tag, "_stall_valid"}, 64'(out_tvalid), 64'(1));
      check({tag, "_stall_data"},  64'(out_tdata),  64'(d));
      check({tag, "_stall_keep"},  64'(out_tkeep),  64'(k));
      check({tag, "_stall_last"},  64'(out_tlast),  64'(l));
      check({tag, "_stall_rdy"},   64'(in_ready),   64'(0));
      @(posedge clock); #1;
    end
    out_tready = 1'b1;
    @(negedge clock);
    check({tag, "_valid"}, 64'(out_tvalid),  64'(1));
    check({tag, "_data"},  64'(out_tdata),   64'(d));
    check({tag, "_keep"},  64'(out_tkeep),   64'(k));
    check({tag, "_last"},  64'(out_tlast),   64'(l));
    check({tag, "_rdy"},   64'(in_ready),    64'(0));
    check({tag, "_clamp"}, 64'(len_clamped), 64'(clamp));
    @(posedge clock); #1;
    out_tready = 1'b0;
  endtask

  task automatic end_pkt(input string tag, input logic [15:0] cnt);
    @(negedge clock);
    check({tag, "_pkt_count"}, 64'(pkt_count),  64'(cnt));
    check({tag, "_idle_valid"}, 64'(out_tvalid), 64'(0));
    check({tag, "_idle_rdy"},  64'(in_ready),   64'(1));
    @(posedge clock); #1;
  endtask

  // Reference beat: bytes 4k..4k+3 of the payload, zero past eff_len.
  function automatic logic [31:0] model_word(input logic [511:0] pl, input int eff, input int k);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++)
      if (4*k + j < eff) w[8*j +: 8] = pl[8*(4*k+j) +: 8];
    return w;
  endfunction

  task automatic recv_payload(input string tag, input logic [511:0] pl, input int eff);
    int nw = (eff + 3) / 4;
    logic [3:0] lk = (eff % 4 == 0) ? 4'hF : 4'(4'hF >> (4 - eff % 4));
    for (int b = 0; b < nw; b++)
      recv_beat($sformatf("%s_b%0d", tag, b), model_word(pl, eff, b),
                (b == nw - 1) ? lk : 4'hF, b == nw - 1, 0, 1'b0);
  endtask

  logic [31:0]  exp1_d [5] = '{32'h56781234, 32'hABCD0012, 32'h03020100, 32'h07060504, 32'h00000908};
  logic [3:0]   exp1_k [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h3};
  logic         exp1_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [511:0] pl_a, pl_b, pl_c;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_src_port = '0;
    in_dst_port = '0; in_length = '0; in_checksum = '0; out_tready = 1'b0;
    pl_a = '0; pl_b = '0;
    for (int i = 0; i < 10; i++) pl_a[8*i +: 8] = 8'(i);
    for (int i = 0; i < 64; i++) pl_b[8*i +: 8] = 8'(8'h40 + i);
    pl_c = ~pl_b;
    pl_c[31:0] = 32'hAABBCCDD;

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_in_ready",  64'(in_ready),    64'(0));
    check("rst_tvalid",    64'(out_tvalid),  64'(0));
    check("rst_tlast",     64'(out_tlast),   64'(0));
    check("rst_tdata",     64'(out_tdata),   64'(0));
    check("rst_tkeep",     64'(out_tkeep),   64'(0));
    check("rst_clamp",     64'(len_clamped), 64'(0));
    check("rst_pkt_count", 64'(pkt_count),   64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock); #1;

    // 10-byte packet, sink always ready
    send(16'd10, 16'h1234, 16'h5678, 16'd18, 16'hABCD, pl_a);
    for (int b = 0; b < 5; b++)
      recv_beat($sformatf("p1_b%0d", b), exp1_d[b], exp1_k[b], exp1_l[b], 0, 1'b0);
    end_pkt("p1", 16'd1);

    // zero-length packet: headers only, tlast on HDR1
    send(16'd0, 16'h0001, 16'h0002, 16'd8, 16'h1111, pl_a);
    recv_beat("p2_h0", 32'h00020001, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p2_h1", 32'h11110008, 4'hF, 1'b1, 0, 1'b0);
    end_pkt("p2", 16'd2);

    // full 64-byte packet
    send(16'd64, 16'hAAAA, 16'h5555, 16'd72, 16'h0000, pl_b);
    recv_beat("p3_h0", 32'h5555AAAA, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p3_h1", 32'h00000048, 4'hF, 1'b0, 0, 1'b0);
    recv_payload("p3", pl_b, 64);
    end_pkt("p3", 16'd3);

    // oversize length clamps to 64 and pulses len_clamped on the HDR0 cycle
    send(16'd100, 16'h0100, 16'h0200, 16'd108, 16'hBEEF, pl_b);
    recv_beat("p4_h0", 32'h02000100, 4'hF, 1'b0, 0, 1'b1);
    recv_beat("p4_h1", 32'hBEEF006C, 4'hF, 1'b0, 0, 1'b0);
    recv_payload("p4", pl_b, 64);
    end_pkt("p4", 16'd4);

    // same as first packet with back-pressure 1,0,0,1,...
    send(16'd10, 16'h1234, 16'h5678, 16'd18, 16'hABCD, pl_a);
    for (int b = 0; b < 5; b++)
      recv_beat($sformatf("p5_b%0d", b), exp1_d[b], exp1_k[b], exp1_l[b], (b % 2 == 1) ? 2 : 0, 1'b0);
    end_pkt("p5", 16'd5);

    // reset during PAY beat 1 aborts the packet
    send(16'd12, 16'h0101, 16'h0202, 16'd20, 16'h3333, pl_b);
    recv_beat("p6_h0", 32'h02020101, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p6_h1", 32'h33330014, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p6_b0", 32'h43424140, 4'hF, 1'b0, 0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("p6_pre_rst_valid", 64'(out_tvalid), 64'(1));
    @(posedge clock); #1;
    @(negedge clock);
    check("p6_rst_valid",     64'(out_tvalid), 64'(0));
    check("p6_rst_pkt_count", 64'(pkt_count),  64'(0));
    check("p6_rst_last",      64'(out_tlast),  64'(0));
    check("p6_rst_keep",      64'(out_tkeep),  64'(0));
    check("p6_rst_data",      64'(out_tdata),  64'(0));
    check("p6_rst_in_ready",  64'(in_ready),   64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("p6_rel_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock); #1;

    // 4-byte packet after reset: exactly one full payload beat
    send(16'd4, 16'h0007, 16'h0009, 16'd12, 16'h0F0F, pl_c);
    recv_beat("p7_h0", 32'h00090007, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p7_h1", 32'h0F0F000C, 4'hF, 1'b0, 0, 1'b0);
    recv_beat("p7_b0", 32'hAABBCCDD, 4'hF, 1'b1, 0, 1'b0);
    end_pkt("p7", 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
